// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video test-pattern transmitter:
//   - default raster timing constants (1280x720 style timing)
//   - counter width
//   - pattern selector enum and controller state enum
//   - pattern_pixel(): luma value for one active pixel
// ---------------------------------------------------------------------------
package video_pkg;

  localparam int unsigned CNT_W = 12;

  // Default raster timing (clocks per horizontal region, lines per vertical region)
  localparam int H_ACTIVE_DEF = 1280;
  localparam int H_FP_DEF     = 110;
  localparam int H_SYNC_DEF   = 40;
  localparam int H_BP_DEF     = 220;
  localparam int V_ACTIVE_DEF = 720;
  localparam int V_FP_DEF     = 5;
  localparam int V_SYNC_DEF   = 5;
  localparam int V_BP_DEF     = 20;
  localparam int IMP_X_DEF    = 640;
  localparam int IMP_Y_DEF    = 360;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECK   = 2'd2,
    PAT_IMPULSE = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Luma for an active pixel at (x, y). imp_hit flags the impulse location,
  // which is decoded by the caller because it depends on module parameters.
  function automatic logic [7:0] pattern_pixel(input pat_e             pat,
                                               input logic [CNT_W-1:0] x,
                                               input logic [CNT_W-1:0] y,
                                               input logic             imp_hit);
    logic [7:0] pix;
    case (pat)
      PAT_HRAMP:   pix = x[7:0];
      PAT_VRAMP:   pix = y[7:0];
      PAT_CHECK:   pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
      PAT_IMPULSE: pix = imp_hit ? 8'hFF : 8'h00;
      default:     pix = 8'h00;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// ---------------------------------------------------------------------------
// video_timing_cnt
// Horizontal/vertical raster position counters with region decode.
// Region order on both axes: active, front porch, sync, back porch.
//
// Ports
//   clk          in   pixel clock
//   rst          in   synchronous reset, active-high (counters to 0)
//   clear_i      in   force counters to (0,0) on the next clock
//   adv_i        in   advance the raster position by one pixel
//   hcnt_o       out  current pixel index within the line
//   vcnt_o       out  current line index within the frame
//   h_act_o      out  hcnt in active region
//   v_act_o      out  vcnt in active region
//   hs_o         out  hcnt in horizontal sync region
//   vs_o         out  vcnt in vertical sync region (whole line)
//   frame_end_o  out  position is the last pixel of the frame
// ---------------------------------------------------------------------------
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             adv_i,
  output logic [CNT_W-1:0] hcnt_o,
  output logic [CNT_W-1:0] vcnt_o,
  output logic             h_act_o,
  output logic             v_act_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             frame_end_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             h_wrap;
  logic             v_wrap;

  assign h_wrap = (hcnt_q == H_LAST);
  assign v_wrap = (vcnt_q == V_LAST);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (clear_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (adv_i) begin
      if (h_wrap) begin
        hcnt_d = '0;
        // vcnt only moves when the line wraps
        vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o      = hcnt_q;
  assign vcnt_o      = vcnt_q;
  assign h_act_o     = (hcnt_q < H_ACT_END);
  assign v_act_o     = (vcnt_q < V_ACT_END);
  assign hs_o        = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vs_o        = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  assign frame_end_o = h_wrap && v_wrap;

endmodule

// File: rtl/video_pattern_gen.sv
// ---------------------------------------------------------------------------
// video_pattern_gen
// Raster timing + 8-bit luma test-pattern source feeding the line-buffer /
// 5x5 FIR input port. Includes a single-pixel impulse pattern so the filter's
// impulse response can be observed in hardware.
//
// Ports
//   clk          in   pixel clock
//   rst          in   synchronous reset, active-high; aborts mid-frame
//   enable       in   run request, level-sensitive
//   pattern_sel  in   0 h-ramp, 1 v-ramp, 2 checker, 3 impulse
//                     (taken only at the first pixel of a frame)
//   y_o          out  luma, 0 whenever dv_o=0
//   dv_o         out  active-video qualifier
//   hs_o         out  horizontal sync, active-high
//   vs_o         out  vertical sync, active-high
//   frame_done   out  one-cycle pulse for the last pixel of each frame
//   busy         out  controller not idle
//
// Handshake: there is no back-pressure. The stream is a free-running
// valid-only interface: a pixel is transferred on every clock with dv_o=1.
//
// Controller: IDLE -> RUN on enable. RUN -> DRAIN when enable drops; DRAIN
// finishes the current frame and returns to IDLE at the last pixel, or goes
// back to RUN (frame continues uninterrupted) if enable returns first.
// All stream outputs are registered and lag the raster position by one clock.
// ---------------------------------------------------------------------------
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int IMP_X    = IMP_X_DEF,
  parameter int IMP_Y    = IMP_Y_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic [7:0] y_o,
  output logic       dv_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [CNT_W-1:0] IMP_X_C = CNT_W'(IMP_X);
  localparam logic [CNT_W-1:0] IMP_Y_C = CNT_W'(IMP_Y);

  state_e state_q;
  pat_e   pat_q;

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             h_act;
  logic             v_act;
  logic             hs_raw;
  logic             vs_raw;
  logic             frame_end;

  logic             running;
  logic             at_origin;
  logic             latch_pat;
  pat_e             pat_cur;
  logic             imp_hit;

  logic [7:0]       y_q, y_d;
  logic             dv_q, dv_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             fd_q, fd_d;

  // -------------------------------------------------------------------------
  // Raster position
  // -------------------------------------------------------------------------
  video_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q == ST_IDLE),
    .adv_i       (running),
    .hcnt_o      (hcnt),
    .vcnt_o      (vcnt),
    .h_act_o     (h_act),
    .v_act_o     (v_act),
    .hs_o        (hs_raw),
    .vs_o        (vs_raw),
    .frame_end_o (frame_end)
  );

  // -------------------------------------------------------------------------
  // Pattern selection
  // -------------------------------------------------------------------------
  assign running   = (state_q != ST_IDLE);
  assign at_origin = (hcnt == '0) && (vcnt == '0);

  // A new pattern is accepted only at the first pixel of a frame in RUN.
  // That first pixel already uses the new selection, so bypass the latch.
  assign latch_pat = (state_q == ST_RUN) && at_origin;
  assign pat_cur   = latch_pat ? pat_e'(pattern_sel) : pat_q;
  assign imp_hit   = (hcnt == IMP_X_C) && (vcnt == IMP_Y_C);

  // -------------------------------------------------------------------------
  // Next output values for the current raster position
  // -------------------------------------------------------------------------
  always_comb begin
    dv_d = running && h_act && v_act;
    y_d  = dv_d ? pattern_pixel(pat_cur, hcnt, vcnt, imp_hit) : 8'h00;
    hs_d = running && hs_raw;
    vs_d = running && vs_raw;
    fd_d = running && frame_end;
  end

  // -------------------------------------------------------------------------
  // Controller FSM, pattern latch and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_HRAMP;
      y_q     <= 8'h00;
      dv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Finishing the frame takes priority over a returning enable.
          if (frame_end)   state_q <= ST_IDLE;
          else if (enable) state_q <= ST_RUN;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (latch_pat) pat_q <= pat_e'(pattern_sel);

      y_q  <= y_d;
      dv_q <= dv_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fd_q <= fd_d;
    end
  end

  assign y_o        = y_q;
  assign dv_o       = dv_q;
  assign hs_o       = hs_q;
  assign vs_o       = vs_q;
  assign frame_done = fd_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_video_pattern_gen.sv
module tb_video_pattern_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int IX = 3, IY = 2;
  localparam int HT = HA + HF + HS + HB;   // 14
  localparam int VT = VA + VF + VS + VB;   // 7
  localparam int TOT = HT * VT;            // 98

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] y_o;
  logic       dv_o, hs_o, vs_o, frame_done, busy;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMP_X(IX), .IMP_Y(IY)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .frame_done(frame_done), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------------------------------------------------------- reference model
  // Frame position is a single pixel index p in 0..TOT-1; x/y derived arithmetically.
  bit         m_on = 0;       // a frame is being produced
  bit         m_stop = 0;     // finish current frame then go idle
  int         m_p = 0;
  logic [1:0] m_pat = 2'd0;
  logic [7:0] e_y;
  logic       e_dv, e_hs, e_vs, e_fd, e_busy;

  // Expected outputs after the clock edge at which (r, e, s) are sampled.
  task automatic model_edge(input logic r, input logic e, input logic [1:0] s);
    int x, yy;
    e_y = 8'h00; e_dv = 0; e_hs = 0; e_vs = 0; e_fd = 0;
    if (r) begin
      m_on = 0; m_stop = 0; m_p = 0;
      e_busy = 0;
    end else if (!m_on) begin
      if (e) begin m_on = 1; m_stop = 0; m_p = 0; end
      e_busy = m_on;
    end else begin
      x  = m_p % HT;
      yy = m_p / HT;
      if (m_p == 0 && !m_stop) m_pat = s;
      e_dv = (x < HA) && (yy < VA);
      if (e_dv) begin
        case (m_pat)
          2'd0: e_y = 8'(x % 256);
          2'd1: e_y = 8'(yy % 256);
          2'd2: e_y = ((((x / 8) + (yy / 8)) % 2) == 1) ? 8'hFF : 8'h00;
          default: e_y = (x == IX && yy == IY) ? 8'hFF : 8'h00;
        endcase
      end
      e_hs = (x >= HA + HF) && (x < HA + HF + HS);
      e_vs = (yy >= VA + VF) && (yy < VA + VF + VS);
      e_fd = (m_p == TOT - 1);
      if (m_stop && m_p == TOT - 1) begin
        m_on = 0; m_stop = 0; m_p = 0;
      end else begin
        m_stop = !e;
        m_p = (m_p + 1) % TOT;
      end
      e_busy = m_on;
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Driver: called at a negedge, applies inputs for one clock, compares all
  // outputs against the model just after the edge, returns at the next negedge.
  task automatic step(input logic r, input logic e, input logic [1:0] s);
    rst = r; enable = e; pattern_sel = s;
    model_edge(r, e, s);
    @(posedge clk);
    #1;
    chk("y", y_o, e_y);
    chk("dv", 8'(dv_o), 8'(e_dv));
    chk("hs", 8'(hs_o), 8'(e_hs));
    chk("vs", 8'(vs_o), 8'(e_vs));
    chk("frame_done", 8'(frame_done), 8'(e_fd));
    chk("busy", 8'(busy), 8'(e_busy));
    @(negedge clk);
  endtask

  // Step until frame_done is seen; n = steps taken. Expired bound is a failure.
  task automatic wait_fd(input int lim, input logic e, input logic [1:0] s, output int n);
    n = 0;
    do begin
      step(1'b0, e, s);
      n++;
    end while (!frame_done && n < lim);
    n_checks++;
    if (!frame_done) begin
      n_errors++;
      $display("FAIL wait_frame_done: got no pulse in %0d cycles, expected one", lim);
    end
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    int         cyc;
    logic [7:0] y;
    logic       dv, hs, vs, fd, bz;
  } vec_t;

  vec_t vt[$];

  initial begin
    int cyc, n, cnt, pos;
    bit en_r;
    logic [1:0] sel_r;

    // Cycle k = sample after the k-th clock edge following enable being driven.
    vt.push_back('{1,   8'h00, 0, 0, 0, 0, 1});
    vt.push_back('{2,   8'h00, 1, 0, 0, 0, 1});
    vt.push_back('{5,   8'h03, 1, 0, 0, 0, 1});
    vt.push_back('{9,   8'h07, 1, 0, 0, 0, 1});
    vt.push_back('{10,  8'h00, 0, 0, 0, 0, 1});
    vt.push_back('{12,  8'h00, 0, 1, 0, 0, 1});
    vt.push_back('{13,  8'h00, 0, 1, 0, 0, 1});
    vt.push_back('{14,  8'h00, 0, 0, 0, 0, 1});
    vt.push_back('{16,  8'h00, 1, 0, 0, 0, 1});
    vt.push_back('{23,  8'h07, 1, 0, 0, 0, 1});
    vt.push_back('{72,  8'h00, 0, 0, 1, 0, 1});
    vt.push_back('{82,  8'h00, 0, 1, 1, 0, 1});
    vt.push_back('{85,  8'h00, 0, 0, 1, 0, 1});
    vt.push_back('{86,  8'h00, 0, 0, 0, 0, 1});
    vt.push_back('{98,  8'h00, 0, 0, 0, 0, 1});
    vt.push_back('{99,  8'h00, 0, 0, 0, 1, 1});
    vt.push_back('{100, 8'h00, 1, 0, 0, 0, 1});

    @(negedge clk);
    step(1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 2'd0);   // rst wins over enable
    chk("reset_busy", 8'(busy), 8'h00);
    chk("reset_dv", 8'(dv_o), 8'h00);

    // 1. h-ramp timing from the table
    step(1'b0, 1'b1, 2'd0);
    cyc = 1;
    foreach (vt[i]) begin
      while (cyc < vt[i].cyc) begin step(1'b0, 1'b1, 2'd0); cyc++; end
      chk($sformatf("tab%0d_y", vt[i].cyc), y_o, vt[i].y);
      chk($sformatf("tab%0d_dv", vt[i].cyc), 8'(dv_o), 8'(vt[i].dv));
      chk($sformatf("tab%0d_hs", vt[i].cyc), 8'(hs_o), 8'(vt[i].hs));
      chk($sformatf("tab%0d_vs", vt[i].cyc), 8'(vs_o), 8'(vt[i].vs));
      chk($sformatf("tab%0d_fd", vt[i].cyc), 8'(frame_done), 8'(vt[i].fd));
      chk($sformatf("tab%0d_busy", vt[i].cyc), 8'(busy), 8'(vt[i].bz));
    end

    // 2. v-ramp: selection taken at next frame; frame_done period 98
    wait_fd(2 * TOT, 1'b1, 2'd1, n);
    wait_fd(2 * TOT, 1'b1, 2'd1, n);
    chk("fd_period", 8'(n), 8'(TOT));

    // 3. impulse: one FF pixel per frame, 32 clocks after the previous frame_done
    wait_fd(2 * TOT, 1'b1, 2'd3, n);
    cnt = 0; pos = -1; n = 0;
    do begin
      step(1'b0, 1'b1, 2'd3);
      n++;
      if (dv_o && y_o == 8'hFF) begin cnt++; pos = n; end
    end while (!frame_done && n < 2 * TOT);
    chk("impulse_count", 8'(cnt), 8'd1);
    chk("impulse_pos", 8'(pos), 8'(2 * HT + IX + 1));

    // 4. mid-frame switch 0 -> 2 is deferred to the next frame
    wait_fd(2 * TOT, 1'b1, 2'd0, n);
    repeat (20) step(1'b0, 1'b1, 2'd0);
    cnt = 0; n = 0;
    do begin
      step(1'b0, 1'b1, 2'd2);
      n++;
      if (dv_o && y_o != 8'h00) cnt++;
    end while (!frame_done && n < 2 * TOT);
    chk("switch_still_ramp", 8'(cnt > 0), 8'd1);
    cnt = 0; n = 0;
    do begin
      step(1'b0, 1'b1, 2'd2);
      n++;
      if (dv_o && y_o != 8'h00) cnt++;   // x<8, y<4: checker is all dark here
    end while (!frame_done && n < 2 * TOT);
    chk("checker_frame", 8'(cnt), 8'd0);

    // 5. enable drop mid-frame: frame completes, then idle
    repeat (30) step(1'b0, 1'b1, 2'd0);
    wait_fd(2 * TOT, 1'b0, 2'd0, n);
    chk("drain_len", 8'(n), 8'(TOT - 30));
    chk("drain_busy", 8'(busy), 8'h00);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 2'd0);
      if (dv_o || hs_o || vs_o || frame_done || busy || y_o != 0) cnt++;
    end
    chk("idle_quiet", 8'(cnt), 8'd0);

    // 6. reset in the middle of an active line, then restart at (0,0)
    step(1'b0, 1'b1, 2'd0);
    repeat (HT + 4) step(1'b0, 1'b1, 2'd0);
    chk("pre_rst_dv", 8'(dv_o), 8'h01);
    step(1'b1, 1'b1, 2'd0);
    chk("rst_dv", 8'(dv_o), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    step(1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd0);
    chk("restart_dv", 8'(dv_o), 8'h01);
    chk("restart_y", y_o, 8'h00);
    step(1'b0, 1'b1, 2'd0);
    chk("restart_y1", y_o, 8'h01);

    // Random stimulus against the model
    en_r = 1; sel_r = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) en_r = !en_r;
      if ($urandom_range(0, 29) == 0) sel_r = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, en_r, sel_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
